// File: rtl/sar_search.sv
// Successive-approximation search engine: drives probe values into an external
// magnitude comparator and resolves the N-bit target from its e/g/l flags.
module sar_search #(
  parameter int N       = 4,
  parameter int CMP_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_e,
  input  logic         cmp_g,
  input  logic         cmp_l,
  output logic [N-1:0] probe,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         found
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = ($clog2(CMP_LAT + 1) > 1) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  probe_q, probe_d;
  logic [N-1:0]  acc_q, acc_d, acc_upd;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  next_mask;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          found_q, found_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      probe_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bit_q    <= '0;
      wcnt_q   <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      wcnt_q   <= wcnt_d;
      found_q  <= found_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    acc_d    = acc_q;
    result_d = result_q;
    bit_d    = bit_q;
    wcnt_d   = wcnt_q;
    found_d  = found_q;
    // Only cmp_g keeps the trial bit; cmp_l and "no flag" both drop it.
    acc_upd   = cmp_g ? probe_q : acc_q;
    next_mask = ONE << (bit_q - BW'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          bit_d   = BW'(N - 1);
          probe_d = ONE << (N - 1);
          wcnt_d  = WW'(CMP_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (cmp_e) begin
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          acc_d = acc_upd;
          if (bit_q == '0) begin
            result_d = acc_upd;
            found_d  = 1'b0;
            state_d  = S_DONE;
          end else begin
            bit_d   = bit_q - 1'b1;
            probe_d = acc_upd | next_mask;
            wcnt_d  = WW'(CMP_LAT);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign probe  = probe_q;
  assign result = result_q;
  assign found  = found_q;
  assign busy   = (state_q == S_WAIT);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a 4-bit combinational-comparator instance and
// an 8-bit instance behind a two-stage pipelined comparator model.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-bit, CMP_LAT=0
  logic       start4;
  logic [3:0] tgt4;
  logic       f_e, f_l;
  logic       e4, g4, l4;
  logic [3:0] probe4, result4;
  logic       busy4, done4, found4;

  assign e4 = f_e | (tgt4 == probe4);
  assign g4 = (tgt4 > probe4);
  assign l4 = f_l | (tgt4 < probe4);

  sar_search #(.N(4), .CMP_LAT(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .cmp_e(e4), .cmp_g(g4), .cmp_l(l4),
    .probe(probe4), .busy(busy4), .done(done4),
    .result(result4), .found(found4)
  );

  // 8-bit, CMP_LAT=2: flags reflect the probe from two cycles earlier
  logic       start8;
  logic [7:0] tgt8;
  logic [7:0] p1, p2;
  logic       e8, g8, l8;
  logic [7:0] probe8, result8;
  logic       busy8, done8, found8;

  always @(posedge clk) begin
    p1 <= probe8;
    p2 <= p1;
  end
  assign e8 = (tgt8 == p2);
  assign g8 = (tgt8 > p2);
  assign l8 = (tgt8 < p2);

  sar_search #(.N(8), .CMP_LAT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .cmp_e(e8), .cmp_g(g8), .cmp_l(l8),
    .probe(probe8), .busy(busy8), .done(done8),
    .result(result8), .found(found8)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({probe4, busy4, done4, result4, found4} !== 11'd0) begin
      bad++;
      $display("FAIL reset4 got probe=%0d busy=%0b done=%0b result=%0d found=%0b want all 0",
               probe4, busy4, done4, result4, found4);
    end
    total++;
    if ({probe8, busy8, done8, result8, found8} !== 19'd0) begin
      bad++;
      $display("FAIL reset8 got probe=%0d busy=%0b done=%0b result=%0d found=%0b want all 0",
               probe8, busy8, done8, result8, found8);
    end
    rst = 1'b0;
  endtask

  // exp_pr packs up to four expected probes, first probe in the top nibble
  task automatic test_search4(input logic [3:0] tgt, input logic [15:0] exp_pr,
                              input int m, input logic [3:0] exp_res, input logic exp_f);
    logic [3:0] ep;
    tgt4 = tgt;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < m; i++) begin
      ep = exp_pr[4*(3-i) +: 4];
      total++;
      if ({probe4, busy4, done4} !== {ep, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL search4 t=%0d step%0d got probe=%0d busy=%0b done=%0b want probe=%0d busy=1 done=0",
                 tgt, i, probe4, busy4, done4, ep);
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if ({done4, busy4, result4, found4} !== {1'b1, 1'b0, exp_res, exp_f}) begin
      bad++;
      $display("FAIL done4 t=%0d got done=%0b busy=%0b result=%0d found=%0b want done=1 busy=0 result=%0d found=%0b",
               tgt, done4, busy4, result4, found4, exp_res, exp_f);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({done4, busy4, result4, found4} !== {1'b0, 1'b0, exp_res, exp_f}) begin
      bad++;
      $display("FAIL idle4 t=%0d got done=%0b busy=%0b result=%0d found=%0b want done=0 busy=0 result=%0d found=%0b",
               tgt, done4, busy4, result4, found4, exp_res, exp_f);
    end
  endtask

  task automatic test_mid_reset();
    tgt4 = 4'd5;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy4, done4, probe4, result4, found4} !== 11'd0) begin
      bad++;
      $display("FAIL midreset got busy=%0b done=%0b probe=%0d result=%0d found=%0b want all 0",
               busy4, done4, probe4, result4, found4);
    end
    rst = 1'b0;
    test_search4(4'd5, {4'd8, 4'd4, 4'd6, 4'd5}, 4, 4'd5, 1'b1);
  endtask

  task automatic test_ignore_start();
    tgt4 = 4'd9;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) start4 = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if ({done4, result4, found4} !== {1'b1, 4'd9, 1'b1}) begin
      bad++;
      $display("FAIL ign_busy got done=%0b result=%0d found=%0b want done=1 result=9 found=1",
               done4, result4, found4);
    end
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    total++;
    if ({busy4, done4, result4, probe4} !== {1'b0, 1'b0, 4'd9, 4'd9}) begin
      bad++;
      $display("FAIL ign_done got busy=%0b done=%0b result=%0d probe=%0d want busy=0 done=0 result=9 probe=9",
               busy4, done4, result4, probe4);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0) begin
      bad++;
      $display("FAIL ign_idle got busy=%0b want 0", busy4);
    end
  endtask

  task automatic test_forced_flags();
    f_e = 1'b1;
    f_l = 1'b1;
    test_search4(4'd3, {4'd8, 12'd0}, 1, 4'd8, 1'b1);
    f_e = 1'b0;
    f_l = 1'b0;
  endtask

  task automatic test_sweep8();
    logic [7:0] prev;
    int cyc;
    bit fin;
    for (int t = 0; t < 256; t++) begin
      tgt8 = 8'(t);
      @(negedge clk);
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      prev = probe8;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 30) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (done8) begin
          fin = 1'b1;
        end else begin
          if (cyc % 3 != 0) begin
            total++;
            if (probe8 !== prev) begin
              bad++;
              $display("FAIL stable8 t=%0d cyc=%0d got probe=%0d want %0d", t, cyc, probe8, prev);
            end
          end
          prev = probe8;
        end
      end
      total++;
      if (!fin) begin
        bad++;
        $display("FAIL timeout8 t=%0d got no done within 30 cycles want done by 24", t);
      end else if ({result8, found8} !== {8'(t), (t != 0)} || cyc > 24 || cyc % 3 != 0) begin
        bad++;
        $display("FAIL sweep8 t=%0d got result=%0d found=%0b cyc=%0d want result=%0d found=%0b cyc<=24 mult of 3",
                 t, result8, found8, cyc, t, (t != 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    tgt4 = '0;
    tgt8 = '0;
    f_e = 1'b0;
    f_l = 1'b0;
    test_reset();
    test_search4(4'd5,  {4'd8, 4'd4,  4'd6,  4'd5},  4, 4'd5,  1'b1);
    test_search4(4'd8,  {4'd8, 12'd0},               1, 4'd8,  1'b1);
    test_search4(4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4, 4'd0,  1'b0);
    test_search4(4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b1);
    test_mid_reset();
    test_ignore_start();
    test_forced_flags();
    test_sweep8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
